// File: rtl/x_23k640_arb_pkg.sv
// Shared types and defaults for the x_23k640 SPI SRAM request arbiter.
package x_23k640_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } arb_state_t;

    localparam int DEF_AW = 16;
    localparam int DEF_DW = 8;

    // Index width for an N-entry requester set, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/x_23k640_arb_rr_pick.sv
// Combinational round-robin pick: first valid requester at or after the pointer, wrapping.
module x_23k640_arb_rr_pick
    import x_23k640_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IW    = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [IW-1:0]    rr,
    output logic [N_REQ-1:0] grant,
    output logic [IW-1:0]    idx,
    output logic             any
);

    logic [IW-1:0] kk;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        kk    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            kk = IW'((int'(rr) + i) % N_REQ);
            if (!any && valid[kk]) begin
                grant[kk] = 1'b1;
                idx       = kk;
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/x_23k640_arb.sv
// Round-robin arbiter sharing one x_23k640 SPI SRAM controller; one transaction in flight,
// completion routed back to the requester that won the grant.
module x_23k640_arb
    import x_23k640_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int AW    = DEF_AW,
    parameter int DW    = DEF_DW
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [N_REQ-1:0]    i_req_valid,
    output logic [N_REQ-1:0]    o_req_accept,
    input  logic [N_REQ-1:0]    i_req_rd_n_wr,
    input  logic [N_REQ*AW-1:0] i_req_addr,
    input  logic [N_REQ*DW-1:0] i_req_wdata,
    output logic [N_REQ-1:0]    o_cpl_ready,
    output logic [DW-1:0]       o_cpl_rdata,
    output logic                o_busy,
    output logic                o_valid,
    input  logic                i_accept,
    output logic                o_rd_n_wr,
    output logic [AW-1:0]       o_addr,
    output logic [DW-1:0]       o_wdata,
    input  logic                i_ready,
    input  logic [DW-1:0]       i_rdata
);

    localparam int IW = idx_w(N_REQ);

    arb_state_t       state_q, state_d;
    logic [IW-1:0]    rr_q;
    logic [IW-1:0]    grant_q;
    logic             rd_n_wr_q;
    logic [AW-1:0]    addr_q;
    logic [DW-1:0]    wdata_q;
    logic [N_REQ-1:0] cpl_ready_q;
    logic [DW-1:0]    cpl_rdata_q;

    logic [N_REQ-1:0] pick_grant;
    logic [IW-1:0]    pick_idx;
    logic             pick_any;
    logic             take;

    x_23k640_arb_rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .valid (i_req_valid),
        .rr    (rr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Accept is suppressed while reset is held so no grant pulse leaks out of reset.
    always_comb begin
        state_d      = state_q;
        take         = 1'b0;
        o_req_accept = '0;
        case (state_q)
            IDLE: begin
                if (pick_any && !i_rst) begin
                    take         = 1'b1;
                    o_req_accept = pick_grant;
                    state_d      = REQ;
                end
            end
            REQ:     if (i_accept) state_d = WAIT;
            WAIT:    if (i_ready)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            grant_q     <= '0;
            rd_n_wr_q   <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpl_ready_q <= '0;
            cpl_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cpl_ready_q <= '0;
            if (take) begin
                grant_q   <= pick_idx;
                rd_n_wr_q <= i_req_rd_n_wr[pick_idx];
                addr_q    <= i_req_addr[int'(pick_idx)*AW +: AW];
                wdata_q   <= i_req_wdata[int'(pick_idx)*DW +: DW];
                rr_q      <= (pick_idx == IW'(N_REQ-1)) ? '0 : pick_idx + IW'(1);
            end
            // Completion data is forwarded for writes too; the requester ignores it.
            if (state_q == WAIT && i_ready) begin
                cpl_ready_q[grant_q] <= 1'b1;
                cpl_rdata_q          <= i_rdata;
            end
        end
    end

    assign o_busy      = (state_q != IDLE);
    assign o_valid     = (state_q == REQ);
    assign o_rd_n_wr   = rd_n_wr_q;
    assign o_addr      = addr_q;
    assign o_wdata     = wdata_q;
    assign o_cpl_ready = cpl_ready_q;
    assign o_cpl_rdata = cpl_rdata_q;

endmodule

// File: tb/tb_x_23k640_arb.sv
// Self-checking bench for x_23k640_arb: directed scenarios plus a randomized run against a
// transaction-level reference model.
module tb_x_23k640_arb;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_accept;
    logic [N-1:0]    req_rd_n_wr;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    cpl_ready;
    logic [DW-1:0]   cpl_rdata;
    logic            busy;
    logic            valid;
    logic            accept;
    logic            rd_n_wr;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
    logic            ready;
    logic [DW-1:0]   rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    x_23k640_arb #(.N_REQ(N), .AW(AW), .DW(DW)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_req_valid   (req_valid),
        .o_req_accept  (req_accept),
        .i_req_rd_n_wr (req_rd_n_wr),
        .i_req_addr    (req_addr),
        .i_req_wdata   (req_wdata),
        .o_cpl_ready   (cpl_ready),
        .o_cpl_rdata   (cpl_rdata),
        .o_busy        (busy),
        .o_valid       (valid),
        .i_accept      (accept),
        .o_rd_n_wr     (rd_n_wr),
        .o_addr        (addr),
        .o_wdata       (wdata),
        .i_ready       (ready),
        .i_rdata       (rdata)
    );

    task automatic step();
        @(negedge clk);
    endtask

    function automatic int oh2i(input logic [N-1:0] v);
        int r = -1;
        int n = 0;
        for (int i = 0; i < N; i++) if (v[i]) begin r = i; n++; end
        return (n == 1) ? r : -1;
    endfunction

    // Controller side: accept now, then i_ready after rdy_delay idle cycles.
    task automatic serve(input int rdy_delay, input logic [DW-1:0] rd);
        accept = 1'b1;
        step();
        accept = 1'b0;
        repeat (rdy_delay) step();
        ready = 1'b1;
        rdata = rd;
        step();
        ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        req_valid = '1; req_rd_n_wr = '1; req_addr = '1; req_wdata = '1;
        accept = 1'b1; ready = 1'b1; rdata = 8'hFF;
        rst = 1'b1;
        step(); step();
        #1;
        checks++; if (req_accept !== '0) begin errors++; $display("FAIL reset_accept got %b want 0", req_accept); end
        checks++; if (valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_valid_busy got %b%b want 00", valid, busy); end
        checks++; if (cpl_ready !== '0 || cpl_rdata !== '0) begin errors++; $display("FAIL reset_cpl got %b/%h want 0/0", cpl_ready, cpl_rdata); end
        checks++; if (addr !== '0 || wdata !== '0 || rd_n_wr !== 1'b0) begin errors++; $display("FAIL reset_payload got %h/%h/%b want 0", addr, wdata, rd_n_wr); end
        req_valid = '0; req_rd_n_wr = '0; req_addr = '0; req_wdata = '0;
        accept = 1'b0; ready = 1'b0; rdata = '0;
        rst = 1'b0;
    endtask

    task automatic test_single_rd();
        step();
        req_valid[1] = 1'b1; req_rd_n_wr[1] = 1'b1; req_addr[1*AW +: AW] = 16'h0123;
        #1;
        checks++; if (req_accept !== 4'b0010) begin errors++; $display("FAIL single_accept got %b want 0010", req_accept); end
        step();
        req_valid = '0;
        #1;
        checks++; if (valid !== 1'b1 || addr !== 16'h0123 || rd_n_wr !== 1'b1) begin errors++; $display("FAIL single_req got v%b a%h r%b want v1 a0123 r1", valid, addr, rd_n_wr); end
        accept = 1'b1;
        step();
        accept = 1'b0;
        #1;
        checks++; if (valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL single_wait got v%b b%b want v0 b1", valid, busy); end
        ready = 1'b1; rdata = 8'hA5;
        step();
        ready = 1'b0;
        #1;
        checks++; if (cpl_ready !== 4'b0010 || cpl_rdata !== 8'hA5) begin errors++; $display("FAIL single_cpl got %b/%h want 0010/a5", cpl_ready, cpl_rdata); end
        step();
        #1;
        checks++; if (cpl_ready !== '0 || cpl_rdata !== 8'hA5 || busy !== 1'b0) begin errors++; $display("FAIL single_after got %b/%h/%b want 0000/a5/0", cpl_ready, cpl_rdata, busy); end
    endtask

    // Pointer sits at 2 after the single read; valid=0011 must wrap to 0, then 1 back-to-back.
    task automatic test_rr_wrap();
        step();
        req_valid = 4'b0011; req_rd_n_wr = '0;
        req_addr[0*AW +: AW] = 16'h1000; req_addr[1*AW +: AW] = 16'h1111;
        #1;
        checks++; if (req_accept !== 4'b0001) begin errors++; $display("FAIL rr_first got %b want 0001", req_accept); end
        step();
        req_valid = 4'b0010;
        #1;
        checks++; if (addr !== 16'h1000 || req_accept !== '0) begin errors++; $display("FAIL rr_payload got %h/%b want 1000/0000", addr, req_accept); end
        serve(0, 8'h11);
        #1;
        checks++; if (cpl_ready !== 4'b0001 || req_accept !== 4'b0010) begin errors++; $display("FAIL rr_b2b got cpl %b acc %b want 0001/0010", cpl_ready, req_accept); end
        step();
        req_valid = '0;
        serve(1, 8'h22);
        #1;
        checks++; if (cpl_ready !== 4'b0010 || cpl_rdata !== 8'h22) begin errors++; $display("FAIL rr_second_cpl got %b/%h want 0010/22", cpl_ready, cpl_rdata); end
        step();
    endtask

    task automatic test_order();
        int got;
        do_reset();
        req_valid = '1;
        for (int k = 0; k < N; k++) req_addr[k*AW +: AW] = AW'(16'h0100 * k);
        for (int i = 0; i < 8; i++) begin
            got = -1;
            for (int t = 0; t < 10; t++) begin
                #1;
                if (req_accept !== '0) begin got = oh2i(req_accept); break; end
                step();
            end
            checks++;
            if (got !== i % N) begin errors++; $display("FAIL order_%0d got %0d want %0d", i, got, i % N); end
            if (got < 0) break;
            step();
            serve(i % 3, DW'(i));
        end
        req_valid = '0;
        step();
    endtask

    task automatic test_stall();
        step();
        req_valid = 4'b0100; req_rd_n_wr[2] = 1'b0;
        req_addr[2*AW +: AW] = 16'hBEEF; req_wdata[2*DW +: DW] = 8'h3C;
        #1;
        checks++; if (req_accept !== 4'b0100) begin errors++; $display("FAIL stall_accept got %b want 0100", req_accept); end
        step();
        req_valid = 4'b1011;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (valid !== 1'b1 || addr !== 16'hBEEF || wdata !== 8'h3C || rd_n_wr !== 1'b0 || req_accept !== '0) begin
                errors++;
                $display("FAIL stall_hold_%0d got v%b a%h w%h r%b acc%b want v1 abeef w3c r0 acc0000", c, valid, addr, wdata, rd_n_wr, req_accept);
            end
            step();
        end
        accept = 1'b1;
        step();
        accept = 1'b0;
        #1;
        checks++; if (req_accept !== '0 || valid !== 1'b0) begin errors++; $display("FAIL stall_wait_noacc got acc%b v%b want 0000/0", req_accept, valid); end
        req_valid = '0;
        ready = 1'b1; rdata = 8'h77;
        step();
        ready = 1'b0;
        #1;
        checks++; if (cpl_ready !== 4'b0100 || cpl_rdata !== 8'h77) begin errors++; $display("FAIL stall_cpl got %b/%h want 0100/77", cpl_ready, cpl_rdata); end
        step();
    endtask

    task automatic test_stray();
        ready = 1'b1; rdata = 8'h55;
        step();
        ready = 1'b0;
        #1;
        checks++; if (cpl_ready !== '0 || busy !== 1'b0 || cpl_rdata !== 8'h77) begin errors++; $display("FAIL stray_ready got %b/%b/%h want 0000/0/77", cpl_ready, busy, cpl_rdata); end
        req_valid = 4'b0001;
        #1;
        checks++; if (req_accept !== 4'b0001) begin errors++; $display("FAIL stray_accept got %b want 0001", req_accept); end
        step();
        req_valid = '0;
        accept = 1'b1;
        step();
        step();
        accept = 1'b0;
        #1;
        checks++; if (busy !== 1'b1 || valid !== 1'b0 || cpl_ready !== '0) begin errors++; $display("FAIL stray_accept_wait got b%b v%b c%b want b1 v0 c0000", busy, valid, cpl_ready); end
        ready = 1'b1; rdata = 8'h99;
        step();
        ready = 1'b0;
        #1;
        checks++; if (cpl_ready !== 4'b0001 || cpl_rdata !== 8'h99) begin errors++; $display("FAIL stray_cpl got %b/%h want 0001/99", cpl_ready, cpl_rdata); end
        step();
    endtask

    task automatic test_reset_mid();
        req_valid = 4'b0010; req_addr[1*AW +: AW] = 16'h4242;
        step();
        req_valid = '0;
        accept = 1'b1;
        step();
        accept = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        ready = 1'b1; rdata = 8'hEE;
        step();
        ready = 1'b0;
        #1;
        checks++;
        if (cpl_ready !== '0 || cpl_rdata !== '0 || busy !== 1'b0 || valid !== 1'b0 || addr !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs got c%b d%h b%b v%b a%h want all 0", cpl_ready, cpl_rdata, busy, valid, addr);
        end
        step();
        req_valid = '1;
        #1;
        checks++; if (cpl_ready !== '0 || req_accept !== 4'b0001) begin errors++; $display("FAIL rstmid_rr got c%b acc%b want 0000/0001", cpl_ready, req_accept); end
        step();
        req_valid = '0;
        serve(0, 8'h01);
        step();
    endtask

    task automatic test_random();
        bit            pend [N];
        logic          m_rd [N];
        logic [AW-1:0] m_addr [N];
        logic [DW-1:0] m_wd [N];
        int            rr_m, g_m, win;
        bit            inflight, presented;
        logic          l_rd;
        logic [AW-1:0] l_addr;
        logic [DW-1:0] l_wd;
        logic [N-1:0]  cpl_exp, acc_exp;
        logic [DW-1:0] rdata_last;
        do_reset();
        rr_m = 0; g_m = 0; inflight = 0; presented = 0;
        l_rd = 0; l_addr = '0; l_wd = '0; cpl_exp = '0; rdata_last = '0;
        for (int k = 0; k < N; k++) begin pend[k] = 0; m_rd[k] = 0; m_addr[k] = '0; m_wd[k] = '0; end
        for (int cyc = 0; cyc < 600; cyc++) begin
            step();
            for (int k = 0; k < N; k++) begin
                if (!pend[k] && $urandom_range(3) == 0) begin
                    pend[k] = 1; m_rd[k] = 1'($urandom); m_addr[k] = AW'($urandom); m_wd[k] = DW'($urandom);
                end else if (pend[k] && $urandom_range(15) == 0) begin
                    pend[k] = 0;
                end
                req_valid[k] = pend[k];
                req_rd_n_wr[k] = m_rd[k];
                req_addr[k*AW +: AW] = m_addr[k];
                req_wdata[k*DW +: DW] = m_wd[k];
            end
            accept = ($urandom_range(2) == 0);
            ready  = ($urandom_range(2) == 0);
            rdata  = DW'($urandom);
            #1;
            win = -1;
            if (!inflight)
                for (int j = 0; j < N; j++)
                    if (win < 0 && pend[(rr_m + j) % N]) win = (rr_m + j) % N;
            acc_exp = (win >= 0) ? N'(1 << win) : '0;
            checks++; if (req_accept !== acc_exp) begin errors++; $display("FAIL rand_accept cyc %0d got %b want %b", cyc, req_accept, acc_exp); end
            checks++; if (valid !== presented || busy !== inflight) begin errors++; $display("FAIL rand_state cyc %0d got v%b b%b want v%b b%b", cyc, valid, busy, presented, inflight); end
            checks++; if (cpl_ready !== cpl_exp || cpl_rdata !== rdata_last) begin errors++; $display("FAIL rand_cpl cyc %0d got %b/%h want %b/%h", cyc, cpl_ready, cpl_rdata, cpl_exp, rdata_last); end
            if (presented) begin
                checks++;
                if (addr !== l_addr || wdata !== l_wd || rd_n_wr !== l_rd) begin
                    errors++;
                    $display("FAIL rand_payload cyc %0d got %h/%h/%b want %h/%h/%b", cyc, addr, wdata, rd_n_wr, l_addr, l_wd, l_rd);
                end
            end
            cpl_exp = '0;
            if (!inflight) begin
                if (win >= 0) begin
                    inflight = 1; presented = 1; g_m = win;
                    l_rd = m_rd[win]; l_addr = m_addr[win]; l_wd = m_wd[win];
                    rr_m = (win + 1) % N;
                    pend[win] = 0;
                end
            end else if (presented) begin
                if (accept) presented = 0;
            end else if (ready) begin
                cpl_exp = N'(1 << g_m);
                rdata_last = rdata;
                inflight = 0;
            end
        end
        step();
        req_valid = '0; accept = 1'b0; ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_rd();
        test_rr_wrap();
        test_order();
        test_stall();
        test_stray();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
